// File: rtl/uart_instruction_handler.sv
// UART receiver: assembles one DATA_BITS-wide instruction per 8N1-style frame
// (1 start, DATA_BITS data LSB first, 1 stop) and presents it as a sticky-ready word.
module uart_instruction_handler #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int unsigned DATA_BITS    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] instruction_out,
  output logic                 instruction_ready
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] out_n;
  logic                 ready_n;
  logic                 rx_meta, rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      idx               <= '0;
      shreg             <= '0;
      instruction_out   <= '0;
      instruction_ready <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      idx               <= idx_n;
      shreg             <= shreg_n;
      instruction_out   <= out_n;
      instruction_ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    out_n   = instruction_out;
    ready_n = instruction_ready;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          idx_n = '0;
          if (!rx_s) begin
            ready_n = 1'b0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          // A low stop bit is a framing error: the word is dropped.
          if (rx_s) begin
            out_n   = shreg;
            ready_n = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_instruction_handler.sv
// Directed bench for uart_instruction_handler: serial frames driven with timed rx edges.
`timescale 1ns/1ps
module tb_uart_instruction_handler;

  localparam int BIT_NS  = 8680;
  localparam int FAST_NS = 8550;
  localparam int SLOW_NS = 8810;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [14:0] instruction_out;
  logic        instruction_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rdy_mid;
  logic [14:0] out_mid;

  uart_instruction_handler dut (
    .clk               (clk),
    .reset             (reset),
    .rx                (rx),
    .instruction_out   (instruction_out),
    .instruction_ready (instruction_ready)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk_out(input string name, input logic [14:0] exp);
    n_checks++;
    if (instruction_out !== exp)
      $display("FAIL %s: instruction_out=%h expected %h", name, instruction_out, exp);
    else n_pass++;
  endtask

  task automatic chk_rdy(input string name, input logic exp);
    n_checks++;
    if (instruction_ready !== exp)
      $display("FAIL %s: instruction_ready=%b expected %b", name, instruction_ready, exp);
    else n_pass++;
  endtask

  // Drives one frame; samples outputs 3/4 into the start bit (after the start is validated).
  task automatic send_frame(input logic [14:0] data, input int bit_ns, input logic stop_val,
                            output logic rdy_s, output logic [14:0] out_s);
    @(negedge clk); #5;
    rx = 1'b0;
    #(bit_ns * 3 / 4);
    rdy_s = instruction_ready;
    out_s = instruction_out;
    #(bit_ns - bit_ns * 3 / 4);
    for (int i = 0; i < 15; i++) begin
      rx = data[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    reset = 1'b1;
    #100;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_out("reset_out", 15'h0000);
    chk_rdy("reset_rdy", 1'b0);
  endtask

  task automatic test_basic();
    send_frame(15'b101010101010101, BIT_NS, 1'b1, rdy_mid, out_mid);
    #5000;
    chk_out("basic_out", 15'h5555);
    chk_rdy("basic_rdy", 1'b1);
  endtask

  task automatic test_back_to_back();
    send_frame(15'h7FFF, BIT_NS, 1'b1, rdy_mid, out_mid);
    chk_out("b2b_first_out", 15'h7FFF);
    chk_rdy("b2b_first_rdy", 1'b1);
    send_frame(15'h0001, BIT_NS, 1'b1, rdy_mid, out_mid);
    n_checks++;
    if (rdy_mid !== 1'b0) $display("FAIL b2b_rdy_clear: ready=%b expected 0", rdy_mid);
    else n_pass++;
    n_checks++;
    if (out_mid !== 15'h7FFF) $display("FAIL b2b_out_hold: out=%h expected 7fff", out_mid);
    else n_pass++;
    #2000;
    chk_out("b2b_second_out", 15'h0001);
    chk_rdy("b2b_second_rdy", 1'b1);
  endtask

  task automatic test_glitch();
    @(negedge clk); #5;
    rx = 1'b0;
    #2000;
    rx = 1'b1;
    #20000;
    chk_out("glitch_out", 15'h0001);
    chk_rdy("glitch_rdy", 1'b1);
    send_frame(15'h4321, BIT_NS, 1'b1, rdy_mid, out_mid);
    #2000;
    chk_out("glitch_recover_out", 15'h4321);
    chk_rdy("glitch_recover_rdy", 1'b1);
  endtask

  task automatic test_framing_error();
    send_frame(15'h1234, BIT_NS, 1'b0, rdy_mid, out_mid);
    #20000;
    rx = 1'b1;
    #(BIT_NS * 20);
    chk_out("frame_err_out", 15'h4321);
    // The start bit was valid, so ready was cleared and no completed word re-set it.
    chk_rdy("frame_err_rdy", 1'b0);
  endtask

  task automatic test_reset_mid_data();
    @(negedge clk); #5;
    rx = 1'b0;
    #(BIT_NS * 6);
    rx = 1'b1;
    #(BIT_NS);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_out("midreset_out", 15'h0000);
    chk_rdy("midreset_rdy", 1'b0);
    #(BIT_NS * 20);
    chk_out("midreset_idle_out", 15'h0000);
    send_frame(15'h0F0F, BIT_NS, 1'b1, rdy_mid, out_mid);
    #2000;
    chk_out("midreset_new_out", 15'h0F0F);
    chk_rdy("midreset_new_rdy", 1'b1);
  endtask

  task automatic test_baud_tolerance();
    send_frame(15'h2AAA, FAST_NS, 1'b1, rdy_mid, out_mid);
    #2000;
    chk_out("fast_out", 15'h2AAA);
    chk_rdy("fast_rdy", 1'b1);
    send_frame(15'h1555, BIT_NS, 1'b1, rdy_mid, out_mid);
    #2000;
    chk_out("between_out", 15'h1555);
    send_frame(15'h2AAA, SLOW_NS, 1'b1, rdy_mid, out_mid);
    n_checks++;
    if (rdy_mid !== 1'b0) $display("FAIL slow_rdy_clear: ready=%b expected 0", rdy_mid);
    else n_pass++;
    #2000;
    chk_out("slow_out", 15'h2AAA);
    chk_rdy("slow_rdy", 1'b1);
  endtask

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_data();
    test_baud_tolerance();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
